// File: rtl/wavetable_pkg.sv
// wavetable_pkg: shared defaults, FSM states and helpers
// for the polyphonic wavetable voice engine.
package wavetable_pkg;

  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_WSEL_W     = 2;
  localparam int DEF_POS_W      = 13;
  localparam int DEF_FRAC_W     = 8;
  localparam int DEF_INC_W      = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_AMP_W      = 8;
  localparam int DEF_REL_STEP   = 1;

  localparam int AMP_MAX = (1 << DEF_AMP_W) - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_WAIT,
    S_MAC,
    S_NEXT,
    S_DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [31:0] sat_w(
    input logic signed [31:0] x,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Table address is the wave select on top of the
  // integer part of the phase.
  function automatic logic [31:0] addr_cat(
    input logic [31:0] wsel,
    input logic [31:0] phase,
    input int          frac_w,
    input int          pos_w
  );
    logic [31:0] pos;
    pos = (phase >> frac_w) & ((32'd1 << pos_w) - 32'd1);
    return (wsel << pos_w) | pos;
  endfunction

endpackage

// File: rtl/wavetable_voice_regs.sv
// wavetable_voice_regs: per-voice phase/inc/wsel/amp/release
// registers; commands override the sequencer's MAC update.
// Ports: clk_50, ar (async low reset), cmd_* voice commands,
//  mac_en/sel MAC update strobe and voice, sel_* read-out of
//  voice sel, active_mask (amp != 0 per voice).
module wavetable_voice_regs
  import wavetable_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int WSEL_W     = DEF_WSEL_W,
  parameter int PH_W       = DEF_POS_W + DEF_FRAC_W,
  parameter int INC_W      = DEF_INC_W,
  parameter int AMP_W      = DEF_AMP_W,
  parameter int REL_STEP   = DEF_REL_STEP
) (
  input  logic                         clk_50,
  input  logic                         ar,
  input  logic                         cmd_valid,
  input  logic [idx_w(NUM_VOICES)-1:0] cmd_voice,
  input  logic                         cmd_key_on,
  input  logic [WSEL_W-1:0]            cmd_wsel,
  input  logic [INC_W-1:0]             cmd_inc,
  input  logic                         mac_en,
  input  logic [idx_w(NUM_VOICES)-1:0] sel,
  output logic [PH_W-1:0]              sel_phase,
  output logic [WSEL_W-1:0]            sel_wsel,
  output logic [AMP_W-1:0]             sel_amp,
  output logic [NUM_VOICES-1:0]        active_mask
);

  localparam int VW = idx_w(NUM_VOICES);

  logic [PH_W-1:0]       phase [NUM_VOICES];
  logic [INC_W-1:0]      inc   [NUM_VOICES];
  logic [WSEL_W-1:0]     wsel  [NUM_VOICES];
  logic [AMP_W-1:0]      amp   [NUM_VOICES];
  logic [NUM_VOICES-1:0] rel;

  always_ff @(posedge clk_50 or negedge ar) begin
    if (!ar) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= '0;
        inc[v]   <= '0;
        wsel[v]  <= '0;
        amp[v]   <= '0;
      end
      rel <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (cmd_valid && cmd_voice == VW'(v)) begin
          if (cmd_key_on) begin
            phase[v] <= '0;
            amp[v]   <= {AMP_W{1'b1}};
            rel[v]   <= 1'b0;
            inc[v]   <= cmd_inc;
            wsel[v]  <= cmd_wsel;
          end else if (amp[v] != '0) begin
            rel[v] <= 1'b1;
          end
        end else if (mac_en && sel == VW'(v)) begin
          phase[v] <= phase[v] + PH_W'(inc[v]);
          if (rel[v]) begin
            amp[v] <= (amp[v] > AMP_W'(REL_STEP))
                    ? amp[v] - AMP_W'(REL_STEP)
                    : '0;
          end
        end
      end
    end
  end

  assign sel_phase = phase[sel];
  assign sel_wsel  = wsel[sel];
  assign sel_amp   = amp[sel];

  always_comb begin
    active_mask = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      active_mask[v] = (amp[v] != '0);
    end
  end

endmodule

// File: rtl/wavetable_voice_engine.sv
// wavetable_voice_engine: per sample_tick, walks all voices over
// one table read port, scales by envelope, mixes and saturates.
// Ports: clk_50, ar (async low reset), sample_tick, cmd_* voice
//  commands, rd_req/rd_addr/rd_valid/rd_data table port,
//  sample_out/sample_valid mixed output, active_mask, overrun.
module wavetable_voice_engine
  import wavetable_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int WSEL_W     = DEF_WSEL_W,
  parameter int POS_W      = DEF_POS_W,
  parameter int FRAC_W     = DEF_FRAC_W,
  parameter int INC_W      = DEF_INC_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int AMP_W      = DEF_AMP_W,
  parameter int REL_STEP   = DEF_REL_STEP
) (
  input  logic                         clk_50,
  input  logic                         ar,
  input  logic                         sample_tick,
  input  logic                         cmd_valid,
  input  logic [idx_w(NUM_VOICES)-1:0] cmd_voice,
  input  logic                         cmd_key_on,
  input  logic [WSEL_W-1:0]            cmd_wsel,
  input  logic [INC_W-1:0]             cmd_inc,
  output logic                         rd_req,
  output logic [WSEL_W+POS_W-1:0]      rd_addr,
  input  logic                         rd_valid,
  input  logic [DATA_W-1:0]            rd_data,
  output logic [DATA_W-1:0]            sample_out,
  output logic                         sample_valid,
  output logic [NUM_VOICES-1:0]        active_mask,
  output logic                         overrun
);

  localparam int VW     = idx_w(NUM_VOICES);
  localparam int PH_W   = POS_W + FRAC_W;
  localparam int ADDR_W = WSEL_W + POS_W;
  localparam int ACC_W  = DATA_W + $clog2(NUM_VOICES) + 1;
  localparam int PR_W   = DATA_W + AMP_W + 1;

  state_t state;
  state_t state_nx;

  logic [VW-1:0]           v;
  logic signed [ACC_W-1:0] acc;
  logic [PH_W-1:0]         cur_phase;
  logic [WSEL_W-1:0]       cur_wsel;
  logic [AMP_W-1:0]        cur_amp;
  logic signed [PR_W-1:0]  prod;
  logic signed [PR_W-1:0]  term;
  logic signed [31:0]      acc_sat;
  logic                    mac_en;
  logic                    last_v;

  wavetable_voice_regs #(
    .NUM_VOICES (NUM_VOICES),
    .WSEL_W     (WSEL_W),
    .PH_W       (PH_W),
    .INC_W      (INC_W),
    .AMP_W      (AMP_W),
    .REL_STEP   (REL_STEP)
  ) u_regs (
    .clk_50      (clk_50),
    .ar          (ar),
    .cmd_valid   (cmd_valid),
    .cmd_voice   (cmd_voice),
    .cmd_key_on  (cmd_key_on),
    .cmd_wsel    (cmd_wsel),
    .cmd_inc     (cmd_inc),
    .mac_en      (mac_en),
    .sel         (v),
    .sel_phase   (cur_phase),
    .sel_wsel    (cur_wsel),
    .sel_amp     (cur_amp),
    .active_mask (active_mask)
  );

  assign mac_en  = (state == S_MAC);
  assign last_v  = (v == VW'(NUM_VOICES - 1));
  assign rd_req  = (state == S_REQ);
  assign rd_addr = ADDR_W'(addr_cat(32'(cur_wsel),
                                    32'(cur_phase),
                                    FRAC_W, POS_W));

  // amp is unsigned, so it gets a zero sign bit before the
  // signed multiply; the shift keeps full scale at ~unity.
  assign prod    = PR_W'($signed(rd_data))
                 * PR_W'($signed({1'b0, cur_amp}));
  assign term    = prod >>> AMP_W;
  assign acc_sat = sat_w(32'(acc), DATA_W);

  always_ff @(posedge clk_50 or negedge ar) begin
    if (!ar) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (sample_tick) state_nx = S_CHECK;
      S_CHECK: state_nx = (cur_amp == '0) ? S_NEXT : S_REQ;
      S_REQ:   state_nx = S_WAIT;
      S_WAIT:  if (rd_valid) state_nx = S_MAC;
      S_MAC:   state_nx = S_NEXT;
      S_NEXT:  state_nx = last_v ? S_DONE : S_CHECK;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge ar) begin
    if (!ar) begin
      v            <= '0;
      acc          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick && state != S_IDLE) overrun <= 1'b1;
      if (state == S_IDLE && sample_tick) begin
        v   <= '0;
        acc <= '0;
      end
      if (state == S_MAC) acc <= acc + ACC_W'(term);
      if (state == S_NEXT && !last_v) v <= v + VW'(1);
      if (state == S_DONE) begin
        sample_out   <= DATA_W'(acc_sat);
        sample_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wavetable_voice_engine.sv
// tb_wavetable_voice_engine: scoreboard bench with a voice model,
// a latency-L table responder and a sample monitor.
module tb_wavetable_voice_engine;
  import wavetable_pkg::*;

  localparam int NV = 4;
  localparam int L  = 2;

  logic        clk_50 = 1'b0;
  logic        ar = 1'b0;
  logic        sample_tick = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_voice = '0;
  logic        cmd_key_on = 1'b0;
  logic [1:0]  cmd_wsel = '0;
  logic [15:0] cmd_inc = '0;
  logic        rd_req;
  logic [14:0] rd_addr;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = '0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic [3:0]  active_mask;
  logic        overrun;

  wavetable_voice_engine dut (
    .clk_50       (clk_50),
    .ar           (ar),
    .sample_tick  (sample_tick),
    .cmd_valid    (cmd_valid),
    .cmd_voice    (cmd_voice),
    .cmd_key_on   (cmd_key_on),
    .cmd_wsel     (cmd_wsel),
    .cmd_inc      (cmd_inc),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .active_mask  (active_mask),
    .overrun      (overrun)
  );

  always #10 clk_50 = ~clk_50;

  logic [20:0] m_ph  [NV];
  logic [15:0] m_inc [NV];
  logic [1:0]  m_ws  [NV];
  int          m_amp [NV];
  bit          m_rel [NV];

  logic [14:0] aq[$];
  int          sq[$];

  int total = 0;
  int bad   = 0;
  int n_req = 0;
  int n_sv  = 0;
  bit hold  = 1'b0;
  bit force_on = 1'b0;
  int force_val = 0;

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [15:0] mem(input logic [14:0] a);
    logic [31:0] t;
    if (force_on) return 16'(force_val);
    t = {17'd0, a} * 32'd40503;
    return t[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [3:0] mask_model();
    logic [3:0] m;
    for (int v = 0; v < NV; v++) m[v] = (m_amp[v] != 0);
    return m;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_ph[v] = '0; m_inc[v] = '0; m_ws[v] = '0;
      m_amp[v] = 0; m_rel[v] = 1'b0;
    end
  endtask

  task automatic model_cmd(input int v, input bit on,
                           input logic [1:0] ws,
                           input logic [15:0] inc);
    if (on) begin
      m_ph[v] = '0; m_amp[v] = AMP_MAX; m_rel[v] = 1'b0;
      m_inc[v] = inc; m_ws[v] = ws;
    end else if (m_amp[v] != 0) begin
      m_rel[v] = 1'b1;
    end
  endtask

  task automatic frame_calc(output int exp, output int nact);
    int acc;
    int d;
    logic [14:0] a;
    acc = 0;
    nact = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_amp[v] != 0) begin
        a = {m_ws[v], m_ph[v][20:8]};
        aq.push_back(a);
        d = mem(a);
        acc += (d * m_amp[v]) >>> 8;
        m_ph[v] = m_ph[v] + 21'(m_inc[v]);
        if (m_rel[v]) m_amp[v] = (m_amp[v] > 1) ? m_amp[v] - 1 : 0;
        nact++;
      end
    end
    exp = (acc > 32767) ? 32767 : ((acc < -32768) ? -32768 : acc);
  endtask

  task automatic drive_cmd(input int v, input bit on,
                           input logic [1:0] ws,
                           input logic [15:0] inc);
    cmd_valid = 1'b1; cmd_voice = 2'(v); cmd_key_on = on;
    cmd_wsel = ws; cmd_inc = inc;
    @(posedge clk_50); #1;
    cmd_valid = 1'b0;
    model_cmd(v, on, ws, inc);
  endtask

  task automatic key(input int v, input bit on,
                     input logic [1:0] ws,
                     input logic [15:0] inc);
    @(posedge clk_50); #1;
    drive_cmd(v, on, ws, inc);
  endtask

  task automatic pulse_tick();
    @(posedge clk_50); #1;
    sample_tick = 1'b1;
    @(posedge clk_50); #1;
    sample_tick = 1'b0;
  endtask

  task automatic wait_sv(input int sv0);
    int w;
    w = 0;
    while (n_sv == sv0 && w < 1000) begin
      @(negedge clk_50);
      w++;
    end
  endtask

  task automatic do_tick(input bit inj);
    int exp, nact, sv0, r0, w;
    frame_calc(exp, nact);
    sq.push_back(exp);
    sv0 = n_sv;
    r0 = n_req;
    pulse_tick();
    if (inj) begin
      w = 0;
      while (!rd_valid && w < 200) begin
        @(negedge clk_50);
        w++;
      end
      chk("inj_rd_valid", rd_valid, 1);
      @(posedge clk_50); #1;
      drive_cmd(0, 1'b1, 2'd1, 16'h0040);
    end
    wait_sv(sv0);
    chk("frame_sv", n_sv, sv0 + 1);
    chk("frame_req", n_req - r0, nact);
    chk("mask", active_mask, mask_model());
  endtask

  initial begin : responder
    logic [14:0] a;
    int w;
    forever begin
      @(posedge clk_50); #1;
      if (rd_req) begin
        n_req++;
        if (aq.size() == 0) chk("rd_unexp", rd_req, 0);
        else chk("rd_addr", rd_addr, aq.pop_front());
        a = rd_addr;
        repeat (L - 1) @(posedge clk_50);
        w = 0;
        while (hold && w < 2000) begin
          @(posedge clk_50);
          w++;
        end
        #1;
        rd_valid = 1'b1;
        rd_data = mem(a);
        @(posedge clk_50); #1;
        rd_valid = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk_50);
      if (sample_valid) begin
        n_sv++;
        if (sq.size() == 0) chk("sv_unexp", sample_valid, 0);
        else chk("sample", $signed(sample_out), sq.pop_front());
      end
    end
  end

  initial begin : watchdog
    #4000000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1);
  end

  initial begin : main
    int exp, nact, sv0, r0;
    model_reset();
    repeat (3) @(posedge clk_50);
    #1;
    chk("rst_sample", sample_out, 0);
    chk("rst_sv", sample_valid, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_mask", active_mask, 0);
    chk("rst_ovr", overrun, 0);
    ar = 1'b1;

    do_tick(0);
    chk("idle_sample", $signed(sample_out), 0);

    key(0, 1'b1, 2'd0, 16'h0100);
    repeat (3) do_tick(0);

    key(1, 1'b1, 2'd1, 16'h0280);
    force_on = 1'b1;
    force_val = 32'h7FFF;
    do_tick(0);
    chk("sat_pos", $signed(sample_out), 32767);
    force_val = -32768;
    do_tick(0);
    chk("sat_neg", $signed(sample_out), -32768);
    force_on = 1'b0;

    key(0, 1'b0, 2'd0, 16'h0000);
    for (int i = 0; i < 256; i++) do_tick(0);
    chk("rel_off", active_mask[0], 0);
    chk("rel_v1_on", active_mask[1], 1);

    key(2, 1'b1, 2'd2, 16'hFFFF);
    for (int i = 0; i < 40; i++) do_tick(0);

    key(0, 1'b1, 2'd3, 16'h0123);
    do_tick(0);
    do_tick(1);
    do_tick(0);

    chk("ovr_pre", overrun, 0);
    hold = 1'b1;
    frame_calc(exp, nact);
    sq.push_back(exp);
    sv0 = n_sv;
    pulse_tick();
    repeat (8) @(posedge clk_50);
    pulse_tick();
    chk("ovr_set", overrun, 1);
    hold = 1'b0;
    wait_sv(sv0);
    repeat (40) @(posedge clk_50);
    #1;
    chk("ovr_one_sv", n_sv, sv0 + 1);
    chk("ovr_sticky", overrun, 1);

    hold = 1'b1;
    frame_calc(exp, nact);
    sv0 = n_sv;
    pulse_tick();
    repeat (4) @(posedge clk_50);
    #1;
    ar = 1'b0;
    #1;
    chk("ar_sample", sample_out, 0);
    chk("ar_sv", sample_valid, 0);
    chk("ar_rd_req", rd_req, 0);
    chk("ar_mask", active_mask, 0);
    chk("ar_ovr", overrun, 0);
    aq.delete();
    sq.delete();
    model_reset();
    r0 = n_req;
    repeat (2) @(posedge clk_50);
    #1;
    hold = 1'b0;
    repeat (3) @(posedge clk_50);
    #1;
    ar = 1'b1;
    repeat (20) @(posedge clk_50);
    #1;
    chk("ar_no_sv", n_sv, sv0);
    chk("ar_no_req", n_req, r0);
    chk("ar_post_sample", sample_out, 0);

    do_tick(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
